// File: rtl/img_pkg.sv
// Shared types and constants for the image write path.
//   rgb_pair_t      : two RGB pixels packed as {R0,G0,B0,R1,G1,B1}, R0 in [47:40]
//   wr_arb_state_e  : image_write_arbiter state encoding (also exported for debug)
//   DEFAULT_WIDTH / DEFAULT_HEIGHT : default image geometry
//   BMP_HEADER_SIZE : byte size of the BMP file header used by the writer
package img_pkg;

    localparam int DEFAULT_WIDTH   = 956;
    localparam int DEFAULT_HEIGHT  = 635;
    localparam int BMP_HEADER_SIZE = 54;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] g0;
        logic [7:0] b0;
        logic [7:0] r1;
        logic [7:0] g1;
        logic [7:0] b1;
    } rgb_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } wr_arb_state_e;

endpackage

// File: rtl/frame_pos_counter.sv
// Frame position counter: tracks the pair index and the (row, pair column)
// of the NEXT pair of a frame. Saturates on the last pair of the frame.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart at pair 0 / row 0 / col 0
//   inc        : one pair consumed
//   col, row   : position of the next pair
//   last       : the next pair is the final pair of the frame
module frame_pos_counter
    import img_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                clear,
    input  logic                                                inc,
    output logic [((WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1)-1:0]    col,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0]      row,
    output logic                                                last
);

    localparam int PAIRS = WIDTH * HEIGHT / 2;
    localparam int COL_W = (WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(PAIRS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
            col <= '0;
            row <= '0;
        end else if (inc && !last) begin
            // Holding at the last pair keeps every field within its maximum.
            cnt <= cnt + CNT_W'(1);
            if (col == COL_W'(WIDTH/2 - 1)) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/image_write_arbiter.sv
// Frame-granular arbiter sharing one image writer port between two pair
// requesters. A requester owns the writer for exactly one full frame; the
// accepted pair is registered onto the DATA_WRITE_* bus with an hsync strobe.
//   HCLK, HRESETn        : clock, synchronous active-low reset
//   en                   : arbitration enable, only looked at in IDLE
//   valid0/1, pair0/1    : requester streams, {R0,G0,B0,R1,G1,B1}
//   ready0/1             : registered, high only for the owner during a frame
//   hsync, DATA_WRITE_*  : one strobe per forwarded pair, data held between
//   grant                : one-hot owner, 0 when idle
//   row, col             : position of the last forwarded pair
//   frame_done           : pulse together with the hsync of the last pair
//   busy                 : a frame is in progress (GRANT or DONE)
//   state                : current arbiter state (debug)
//
// Handshake: a pair transfers on a rising edge where valid and ready are both
// high. ready is registered and never depends on valid; the requester must
// hold its pair stable until it transfers.
module image_write_arbiter
    import img_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic                                                HCLK,
    input  logic                                                HRESETn,
    input  logic                                                en,
    input  logic                                                valid0,
    input  logic                                                valid1,
    input  logic [47:0]                                         pair0,
    input  logic [47:0]                                         pair1,
    output logic                                                ready0,
    output logic                                                ready1,
    output logic                                                hsync,
    output logic [7:0]                                          DATA_WRITE_R0,
    output logic [7:0]                                          DATA_WRITE_G0,
    output logic [7:0]                                          DATA_WRITE_B0,
    output logic [7:0]                                          DATA_WRITE_R1,
    output logic [7:0]                                          DATA_WRITE_G1,
    output logic [7:0]                                          DATA_WRITE_B1,
    output logic [1:0]                                          grant,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0]      row,
    output logic [((WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1)-1:0]    col,
    output logic                                                frame_done,
    output logic                                                busy,
    output wr_arb_state_e                                       state
);

    localparam int COL_W = (WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    if (WIDTH % 2 != 0) begin : g_width_check
        $error("image_write_arbiter: WIDTH must be even");
    end

    rgb_pair_t        data_q;
    logic             last_owner;   // index of the previous frame's owner
    logic             start;
    logic             accept;
    logic [1:0]       pick;
    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic             pos_last;

    assign start  = en && (valid0 || valid1);
    assign accept = (ready0 && valid0) || (ready1 && valid1);

    // Round-robin on a tie: the requester that did not own the last frame.
    always_comb begin
        pick = 2'b00;
        if (valid0 && valid1) begin
            pick = last_owner ? 2'b01 : 2'b10;
        end else if (valid0) begin
            pick = 2'b01;
        end else if (valid1) begin
            pick = 2'b10;
        end
    end

    frame_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .clear (state == ST_IDLE && start),
        .inc   (accept),
        .col   (pos_col),
        .row   (pos_row),
        .last  (pos_last)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            ready0     <= 1'b0;
            ready1     <= 1'b0;
            hsync      <= 1'b0;
            data_q     <= '0;
            row        <= '0;
            col        <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            hsync      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        grant <= pick;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    ready0 <= grant[0];
                    ready1 <= grant[1];
                    if (accept) begin
                        hsync  <= 1'b1;
                        data_q <= grant[1] ? rgb_pair_t'(pair1) : rgb_pair_t'(pair0);
                        row    <= pos_row;
                        col    <= pos_col;
                        if (pos_last) begin
                            ready0     <= 1'b0;
                            ready1     <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    last_owner <= grant[1];
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign DATA_WRITE_R0 = data_q.r0;
    assign DATA_WRITE_G0 = data_q.g0;
    assign DATA_WRITE_B0 = data_q.b0;
    assign DATA_WRITE_R1 = data_q.r1;
    assign DATA_WRITE_G1 = data_q.g1;
    assign DATA_WRITE_B1 = data_q.b1;

endmodule
